// File: rtl/reg_gate_pkg.sv
// Shared constants for the gated delay-line block: output-gating encodings,
// parameter defaults and the legal parameter ranges.
package reg_gate_pkg;

   // Output-gating selection carried on MODE
   localparam logic MODE_AND = 1'b0;
   localparam logic MODE_XOR = 1'b1;

   // Data width: default and legal range
   localparam int WIDTH_DEFAULT = 4;
   localparam int WIDTH_MIN     = 1;
   localparam int WIDTH_MAX     = 32;

   // Delay-line depth: default and legal range
   localparam int DEPTH_DEFAULT = 1;
   localparam int DEPTH_MIN     = 1;
   localparam int DEPTH_MAX     = 16;

endpackage : reg_gate_pkg

// File: rtl/dff_en_rst.sv
// One delay-line stage: a WIDTH-wide register with load enable and
// synchronous active-high clear.
module dff_en_rst #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

   // Next-state: load D when enabled, otherwise hold
   always_comb begin
      // NOTE: default assignment first so every path drives q_d and no latch is inferred.
      q_d = q_q;
      if (EN) begin
         q_d = D;
      end
   end

   // State register; clear wins over load
   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (RST) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign Q = q_q;

endmodule : dff_en_rst

// File: rtl/reg_gate_pipe.sv
// Combinational OR path plus a DEPTH-stage delay line of ~I1 whose tail is
// gated against I0 (AND or XOR), with a saturating fill counter that flags
// when the delay line holds only post-reset data.
module reg_gate_pipe
   import reg_gate_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             MODE,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   output logic [WIDTH-1:0] O0,
   output logic [WIDTH-1:0] O1,
   output logic             VALID
);

   localparam int                CNT_W     = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(DEPTH);

   // Reject out-of-range parameters at elaboration
   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("reg_gate_pipe: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
   end
   if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
      $error("reg_gate_pipe: DEPTH=%0d outside %0d..%0d", DEPTH, DEPTH_MIN, DEPTH_MAX);
   end

   logic [DEPTH-1:0][WIDTH-1:0] stage_d;
   logic [DEPTH-1:0][WIDTH-1:0] stage_q;
   logic [WIDTH-1:0]            tail;
   logic [CNT_W-1:0]            fill_d;
   logic [CNT_W-1:0]            fill_q;

   // Delay-line inputs: head takes inverted operand B, others take the previous stage
   always_comb begin
      stage_d    = stage_q;
      stage_d[0] = ~I1;
      for (int k = 1; k < DEPTH; k++) begin
         stage_d[k] = stage_q[k-1];
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      dff_en_rst #(
         .WIDTH (WIDTH)
      ) u_stage (
         .CLK (CLK),
         .RST (RST),
         .EN  (EN),
         .D   (stage_d[k]),
         .Q   (stage_q[k])
      );
   end

   // Fill counter: count enabled edges, stop at DEPTH
   always_comb begin
      fill_d = fill_q;
      if (EN && (fill_q != FILL_FULL)) begin
         fill_d = fill_q + CNT_W'(1);
      end
   end

   // Fill counter register; reset discards any partial fill
   always_ff @(posedge CLK) begin
      if (RST) begin
         fill_q <= '0;
      end else begin
         fill_q <= fill_d;
      end
   end

   assign tail  = stage_q[DEPTH-1];
   assign O0    = I0 | I1;
   assign VALID = (fill_q == FILL_FULL);

   // Output gating of the delay-line tail against operand A
   always_comb begin
      O1 = tail & I0;
      if (MODE == MODE_XOR) begin
         O1 = tail ^ I0;
      end
   end

endmodule : reg_gate_pipe

// File: doc/reg_gate_pipe.md
REG_GATE_PIPE -- requirements
Module: reg_gate_pipe

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the bit width of the data inputs and outputs (legal: 1..32).
REQ-002 Parameter DEPTH, default 1, SHALL set the number of register stages on the delayed path (legal: 1..16).
REQ-003 Port CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port RST  input  1  SHALL be the synchronous, active-high reset.
REQ-005 Port EN  input  1  SHALL be the shift enable for the delay line.
REQ-006 Port MODE  input  1  SHALL select the output-gating function: 0 = AND, 1 = XOR.
REQ-007 Port I0  input  WIDTH  SHALL be data operand A.
REQ-008 Port I1  input  WIDTH  SHALL be data operand B.
REQ-009 Port O0  output  WIDTH  SHALL be the combinational result.
REQ-010 Port O1  output  WIDTH  SHALL be the registered, gated result.
REQ-011 Port VALID  output  1  SHALL indicate that the delay line is fully primed.

Function
REQ-012 O0 SHALL equal I0 | I1 bitwise, with zero latency and independent of EN, MODE and RST.
REQ-013 The delay line SHALL hold DEPTH stages S[0..DEPTH-1], each WIDTH bits wide.
REQ-014 When EN=1 on a rising edge, S[0] SHALL load ~I1 and S[k] SHALL load S[k-1] for k = 1..DEPTH-1.
REQ-015 When EN=0, all stages SHALL hold their values.
REQ-016 O1 SHALL equal S[DEPTH-1] & I0 when MODE=0.
REQ-017 O1 SHALL equal S[DEPTH-1] ^ I0 when MODE=1.
REQ-018 O1 SHALL respond combinationally to I0 and MODE; the latency from I1 to O1 SHALL be exactly DEPTH enabled cycles.
REQ-019 A fill counter of width clog2(DEPTH+1) SHALL increment on each enabled edge and saturate at DEPTH.
REQ-020 VALID SHALL be 1 exactly when the fill counter equals DEPTH; EN=0 SHALL NOT clear VALID.
REQ-021 With DEPTH=1 and MODE=0, the block SHALL be cycle-equivalent after reset to: O0 = I0|I1; O1 = reg(~I1) & I0.
REQ-022 RST SHALL have priority over EN when both are asserted on the same edge.

Reset
REQ-023 On a rising CLK edge with RST=1, all stages SHALL clear to 0 and the fill counter SHALL clear to 0.
REQ-024 While stages are 0, O1 SHALL be 0 in AND mode and SHALL equal I0 in XOR mode; VALID SHALL be 0.
REQ-025 RST asserted mid-fill or mid-stream SHALL discard all in-flight data; refill SHALL restart from count 0.
REQ-026 O0 SHALL be unaffected by RST.

Structure
REQ-027 Package reg_gate_pkg SHALL hold the MODE encodings (MODE_AND=0, MODE_XOR=1), the defaults for WIDTH and DEPTH, and their legal limits.
REQ-028 Each stage SHALL be one instance of a sub-module dff_en_rst (WIDTH-wide register with D, EN, CLK, RST, Q), instantiated DEPTH times through a generate loop.
REQ-029 Illegal parameter values SHALL trigger an elaboration-time error.

Verification
REQ-030 WIDTH=4, DEPTH=1, MODE=0: after reset, apply I1=0011, then I0=1111 with EN=1 -> O0=1111 immediately; O1=1100 one edge later; VALID=1 after the first enabled edge.
REQ-031 DEPTH=3: apply I1=0001, 0010, 0100 on successive enabled edges with I0=1111 -> O1=1110, 1101, 1011 on edges 3, 4, 5; VALID rises on edge 3.
REQ-032 EN=0 for 5 cycles mid-stream -> S and O1 hold; the fill counter is not incremented; VALID is unchanged.
REQ-033 MODE toggles 0->1 with S[DEPTH-1]=1010 and I0=0110 -> O1 changes from 0010 to 1100 in the same cycle.
REQ-034 RST and EN both high at DEPTH=3 with VALID=1 -> on the next edge, O1=0 (AND mode) and VALID=0; the 3 subsequent enabled edges re-assert VALID.
REQ-035 Random stimulus at DEPTH=1, MODE=0 against a scoreboard model of O1 = reg(~I1) & I0 -> zero mismatches over 10k cycles.
